// File: rtl/hex_pio_ctrl.sv
// hex_pio_ctrl: Avalon-MM slave driving six 7-segment digits with blink,
// plus a debounced switch status register with a change interrupt.
module hex_pio_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned BLINK_RST  = 12499999,
    parameter int unsigned SW_W       = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      AVS_ADDRESS,
    input  logic            AVS_READ,
    input  logic            AVS_WRITE,
    input  logic [31:0]     AVS_WRITEDATA,
    output logic [31:0]     AVS_READDATA,
    output logic            INS_IRQ,
    input  logic [SW_W-1:0] SW,
    output logic [41:0]     NHEX
);
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    logic [23:0]     data_q, data_d;
    logic [5:0]      en_q, en_d, blk_q, blk_d;
    logic            irq_en_q, irq_en_d;
    logic [25:0]     div_q, div_d, cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [SW_W-1:0] sync1_q, sync2_q, samp_q, samp_d, deb_q, deb_d;
    logic [31:0]     dcnt_q, dcnt_d;
    logic            chg_q, chg_d, irq_q;
    logic [31:0]     rdata_q, rdata_d, status;
    logic [41:0]     nhex_q, nhex_d;
    logic            wr0, wr1, wr2, wr3, tick;

    always_comb begin
        wr0      = AVS_WRITE && AVS_ADDRESS == 2'd0;
        wr1      = AVS_WRITE && AVS_ADDRESS == 2'd1;
        wr2      = AVS_WRITE && AVS_ADDRESS == 2'd2;
        wr3      = AVS_WRITE && AVS_ADDRESS == 2'd3;
        data_d   = wr0 ? AVS_WRITEDATA[23:0] : data_q;
        en_d     = wr1 ? AVS_WRITEDATA[5:0] : en_q;
        blk_d    = wr1 ? AVS_WRITEDATA[13:8] : blk_q;
        irq_en_d = wr1 ? AVS_WRITEDATA[16] : irq_en_q;
        div_d    = wr2 ? AVS_WRITEDATA[25:0] : div_q;
        // a BLINK_DIV write restarts the period in the lit phase
        cnt_d    = wr2 ? AVS_WRITEDATA[25:0] : cnt_q == '0 ? div_q : cnt_q - 26'd1;
        phase_d  = wr2 ? 1'b0 : cnt_q == '0 ? ~phase_q : phase_q;
        tick     = dcnt_q == 32'(DEB_CYCLES - 1);
        dcnt_d   = tick ? '0 : dcnt_q + 32'd1;
        samp_d   = tick ? sync2_q : samp_q;
        deb_d    = (tick && sync2_q == samp_q && sync2_q != deb_q) ? sync2_q : deb_q;
        // a new debounced change beats a same-cycle write-1-clear
        chg_d    = (deb_d != deb_q) || (chg_q && !(wr3 && AVS_WRITEDATA[31]));
        status   = {chg_q, {(31 - SW_W){1'b0}}, deb_q};
        rdata_d  = !AVS_READ ? rdata_q :
                   AVS_ADDRESS == 2'd0 ? {8'b0, data_q} :
                   AVS_ADDRESS == 2'd1 ? {15'b0, irq_en_q, 2'b0, blk_q, 2'b0, en_q} :
                   AVS_ADDRESS == 2'd2 ? {6'b0, div_q} : status;
        nhex_d   = '1;
        for (int i = 0; i < 6; i++)
            nhex_d[7*i +: 7] = (!en_q[i] || (blk_q[i] && phase_q)) ? 7'h7f : SEG[data_q[4*i +: 4]];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q   <= '0;
            en_q     <= '0;
            blk_q    <= '0;
            irq_en_q <= 1'b0;
            div_q    <= 26'(BLINK_RST);
            cnt_q    <= 26'(BLINK_RST);
            phase_q  <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            samp_q   <= '0;
            deb_q    <= '0;
            dcnt_q   <= '0;
            chg_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            nhex_q   <= '1;
        end else begin
            data_q   <= data_d;
            en_q     <= en_d;
            blk_q    <= blk_d;
            irq_en_q <= irq_en_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sync1_q  <= SW;
            sync2_q  <= sync1_q;
            samp_q   <= samp_d;
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            chg_q    <= chg_d;
            irq_q    <= chg_q && irq_en_q;
            rdata_q  <= rdata_d;
            nhex_q   <= nhex_d;
        end
    end

    assign AVS_READDATA = rdata_q;
    assign INS_IRQ      = irq_q;
    assign NHEX         = nhex_q;
endmodule

// File: doc/hex_pio_ctrl.md
Name: hex_pio_ctrl

Overview:
- Avalon-MM slave peripheral that owns all six 7-segment displays (HEX0-HEX5) and the slide-switch inputs for the Nios II system.
- Holds per-digit nibble registers, a digit-enable mask and a blink mask, and runs a programmable blink timer.
- Debounces the switches and raises an interrupt on a debounced change.
- Instantiated as a Qsys component; its conduit drives the board HEX pins and takes SW[3:0].

Parameters:
- DEB_CYCLES, 500000: clocks between debounce samples (10 ms at 50 MHz).
- BLINK_RST, 12499999: reset value of the BLINK_DIV register (half-period of 0.25 s at 50 MHz).
- SW_W, 4: number of switch inputs.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- AVS_ADDRESS  in  2  word address.
- AVS_READ  in  1  read strobe.
- AVS_WRITE  in  1  write strobe.
- AVS_WRITEDATA  in  32  write data.
- AVS_READDATA  out  32  read data, read latency 1.
- INS_IRQ  out  1  interrupt, level, active-high.
- SW  in  SW_W  raw switch inputs, asynchronous.
- NHEX  out  42  active-low segments; [6:0]=HEX0 … [41:35]=HEX5, bit order gfedcba.

Behaviour:
- Reset (async on RST_N=0, released synchronously by CLK):
  - DATA=0, CTRL=0, BLINK_DIV=BLINK_RST, blink counter=BLINK_RST, blink phase=0.
  - Debounced SW=0, CHG=0, IRQ_EN=0, sync/sample flops=0.
  - AVS_READDATA=0, INS_IRQ=0, NHEX=42'h3ffffffffff (all digits blank).
- Register map:
  - 0 DATA rw: [23:0] six hex nibbles, digit i = [4i+3:4i].
  - 1 CTRL rw: [5:0] digit enable, [13:8] blink mask, [16] IRQ_EN; other bits read 0.
  - 2 BLINK_DIV rw: [25:0] blink half-period minus 1; other bits read 0.
  - 3 STATUS: [SW_W-1:0] debounced SW (ro), [31] CHG. Writing 1 to bit 31 clears CHG; reading does not clear it.
- Writes:
  - A register updates on the CLK edge where AVS_WRITE=1; the new value is visible on NHEX on the following edge (NHEX is registered).
  - A write to BLINK_DIV also reloads the blink counter and forces phase=0.
- Reads: AVS_READDATA is registered and valid the cycle after AVS_READ=1. It holds its value otherwise; it is not cleared. No wait states.
- Simultaneous AVS_READ and AVS_WRITE: the write takes effect; the read returns the pre-write value.
- Blink timer:
  - Down-counter; at 0 it reloads BLINK_DIV and toggles phase.
  - BLINK_DIV=0 toggles phase every clock.
- Digit output:
  - digit i = 7'h7f if enable[i]=0, or if blink[i]=1 and phase=1.
  - Otherwise digit i = active-low decode of its nibble: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0e (hex).
- Debounce:
  - SW passes through a 2-flop synchronizer.
  - A sample counter pulses every DEB_CYCLES clocks.
  - The debounced value updates only when two consecutive samples are equal and differ from the current debounced value.
- CHG flag:
  - Sets on any debounced-value change.
  - If a set and a write-1-clear occur in the same cycle, the set wins.
- INS_IRQ: registered; equals CHG & IRQ_EN, one cycle after either changes.

Test Plan:
- Reset: hold RST_N=0 → NHEX=3ffffffffff, INS_IRQ=0. Read addr 2 → 00bebc1f.
- Digit decode: write DATA=00fedcba, CTRL=0000003f → two cycles later NHEX = {0e,06,21,46,03,08} (HEX5..HEX0). Write CTRL=00000005 → only HEX0 (08) and HEX2 (46) lit, all others 7f.
- Blink: DEB_CYCLES=4, BLINK_DIV=3, CTRL=0000013f (blink HEX0) → HEX0 alternates lit/7f every 4 clocks; other digits steady. A write to BLINK_DIV mid-period restarts the phase at lit.
- Debounce: DEB_CYCLES=4; SW toggles 0→5 with a 1-sample glitch → no change. SW held at 5 for 3 samples → STATUS[3:0]=5, CHG=1. With IRQ_EN=1, INS_IRQ=1 one cycle after CHG.
- CHG clear race: a write of 80000000 to addr 3 in the same cycle as a new debounced change → CHG stays 1. The same write in an idle cycle → CHG=0 and INS_IRQ=0 next cycle.
- Async reset mid-operation: assert RST_N during blinking with CHG=1 → NHEX blank and INS_IRQ=0 immediately. After release, registers return to their reset values.
